alu_cmd_sequencer: RTL

Sequential front-end for the combinational arithmetic breadboard (add/sub/mul/div/mod). Buffers operation requests in a small command queue and drives the ALU operand/opcode lines from registers. It waits a fixed settle time, captures `output1`/`err_code`, and returns each result with a valid/ready handshake. It is the requesting end of the ALU interface and replaces the testbench-style direct driving of the breadboard.

---
 rtl/alu_cmd_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command-queue front-end for the combinational arithmetic ALU: queues requests,
// holds operands for a settle time, captures the result and returns it via valid/ready.
module alu_cmd_sequencer #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 4,
   parameter int SETTLE = 1,
   parameter int ERRW   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic [3:0]       cmd_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_op,
   input  logic [31:0]      alu_result,
   input  logic [1:0]       alu_err,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_result,
   output logic [1:0]       rsp_err,
   output logic [3:0]       rsp_op,
   output logic             busy,
   output logic [ERRW-1:0]  err_count
);

   // state   | meaning
   // IDLE    | nothing in flight; pop as soon as the queue is non-empty
   // ISSUE   | alu_* driven, waiting SETTLE cycles before capture
   // RESPOND | rsp_valid high, rsp_* frozen until accepted
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESPOND} state_t;

   localparam int AW   = $clog2(DEPTH);
   localparam int CNTW = AW + 1;
   localparam int CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   logic [WIDTH-1:0] qa_q  [DEPTH];
   logic [WIDTH-1:0] qb_q  [DEPTH];
   logic [3:0]       qop_q [DEPTH];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;

   state_t           state_q, state_d;
   logic [CW-1:0]    settle_q, settle_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [3:0]       alu_op_q, alu_op_d;
   logic [31:0]      rsp_result_q, rsp_result_d;
   logic [1:0]       rsp_err_q, rsp_err_d;
   logic [3:0]       rsp_op_q, rsp_op_d;
   logic [ERRW-1:0]  err_count_q, err_count_d;

   logic             push, pop, empty, err_inc;
   logic [WIDTH-1:0] head_a, head_b;
   logic [3:0]       head_op;

   // No bypass: a full queue refuses even if the FSM pops on the same edge.
   assign cmd_ready = (cnt_q != CNTW'(DEPTH));
   assign empty     = (cnt_q == '0);
   assign push      = cmd_valid & cmd_ready;
   assign head_a    = qa_q[rd_ptr_q];
   assign head_b    = qb_q[rd_ptr_q];
   assign head_op   = qop_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (push) begin
         qa_q[wr_ptr_q]  <= cmd_a;
         qb_q[wr_ptr_q]  <= cmd_b;
         qop_q[wr_ptr_q] <= cmd_op;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      cnt_d = cnt_q + CNTW'(1);
      else if (pop && !push) cnt_d = cnt_q - CNTW'(1);
   end

   always_comb begin
      state_d      = state_q;
      settle_d     = settle_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      rsp_result_d = rsp_result_q;
      rsp_err_d    = rsp_err_q;
      rsp_op_d     = rsp_op_q;
      err_count_d  = err_count_q;
      pop          = 1'b0;
      err_inc      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!empty) pop = 1'b1;
         end
         S_ISSUE: begin
            if (settle_q == CW'(SETTLE - 1)) begin
               rsp_result_d = alu_result;
               rsp_err_d    = alu_err;
               rsp_op_d     = alu_op_q;
               err_inc      = (alu_err != 2'b00);
               state_d      = S_RESPOND;
            end else begin
               settle_d = settle_q + CW'(1);
            end
         end
         S_RESPOND: begin
            if (rsp_ready) begin
               if (!empty) pop = 1'b1;
               else        state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Illegal opcodes never reach the ALU; they are answered directly.
      if (pop) begin
         if (head_op <= 4'd4) begin
            alu_a_d  = head_a;
            alu_b_d  = head_b;
            alu_op_d = head_op;
            settle_d = '0;
            state_d  = S_ISSUE;
         end else begin
            rsp_result_d = '0;
            rsp_err_d    = 2'b11;
            rsp_op_d     = head_op;
            err_inc      = 1'b1;
            state_d      = S_RESPOND;
         end
      end

      if (err_inc && (err_count_q != '1)) err_count_d = err_count_q + ERRW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         state_q      <= S_IDLE;
         settle_q     <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         rsp_result_q <= '0;
         rsp_err_q    <= '0;
         rsp_op_q     <= '0;
         err_count_q  <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         state_q      <= state_d;
         settle_q     <= settle_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         rsp_result_q <= rsp_result_d;
         rsp_err_q    <= rsp_err_d;
         rsp_op_q     <= rsp_op_d;
         err_count_q  <= err_count_d;
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_op     = alu_op_q;
   assign rsp_valid  = (state_q == S_RESPOND);
   assign rsp_result = rsp_result_q;
   assign rsp_err    = rsp_err_q;
   assign rsp_op     = rsp_op_q;
   assign busy       = (state_q != S_IDLE) || !empty;
   assign err_count  = err_count_q;

endmodule
